// File: rtl/rv32i_test_monitor_pkg.sv
// Shared definitions for the riscv-tests completion monitor: FSM encoding and
// the register indices the riscv-tests harness uses for its handshake.
package rv32i_test_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_SETTLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [4:0] REG_TESTNUM = 5'd3;
   localparam logic [4:0] REG_DONE    = 5'd26;
   localparam logic [4:0] REG_RESULT  = 5'd27;

endpackage

// File: rtl/rv32i_wb_shadow.sv
// Shadows x3/x26/x27 from the register-file write port. The *_nxt outputs
// include a same-cycle write so the verdict can see a write landing on its sample cycle.
module rv32i_wb_shadow
   import rv32i_test_monitor_pkg::*;
(
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic [31:0] testnum_nxt,
   output logic [31:0] done_nxt,
   output logic [31:0] result_nxt
);

   logic [31:0] testnum_q;
   logic [31:0] done_q;
   logic [31:0] result_q;

   always_comb begin
      testnum_nxt = testnum_q;
      done_nxt    = done_q;
      result_nxt  = result_q;
      if (clr) begin
         testnum_nxt = '0;
         done_nxt    = '0;
         result_nxt  = '0;
      end else if (en && wb_en && (wb_rd != 5'd0)) begin
         case (wb_rd)
            REG_TESTNUM: testnum_nxt = wb_data;
            REG_DONE:    done_nxt    = wb_data;
            REG_RESULT:  result_nxt  = wb_data;
            default:     ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         testnum_q <= '0;
         done_q    <= '0;
         result_q  <= '0;
      end else begin
         testnum_q <= testnum_nxt;
         done_q    <= done_nxt;
         result_q  <= result_nxt;
      end
   end

endmodule

// File: rtl/rv32i_test_monitor.sv
// riscv-tests completion monitor: snoops core writebacks, waits a settle window
// after x26 goes non-zero, then latches a PASS/FAIL/TIMEOUT verdict.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | out of reset, writebacks ignored
//   ST_RUN    | test running, shadows tracking, timeout armed
//   ST_SETTLE | x26 seen non-zero, letting trailing x3/x27 writes land
//   ST_DONE   | verdict held until next start_i
module rv32i_test_monitor
   import rv32i_test_monitor_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 20,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [31:0] PASS_VALUE     = 32'd1
) (
   input  logic        sys_clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        wb_en_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        pass_o,
   output logic        fail_o,
   output logic        timeout_o,
   output logic [31:0] fail_testnum_o,
   output logic [31:0] cycle_count_o
);

   localparam int unsigned  SW           = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
   localparam logic [31:0]  TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   state_t        state;
   state_t        state_nxt;
   logic [31:0]   cycle_cnt;
   logic [SW-1:0] settle_cnt;
   logic [31:0]   testnum_nxt;
   logic [31:0]   done_nxt;
   logic [31:0]   result_nxt;
   logic          shadow_en;
   logic          trigger;
   logic          timeout_hit;
   logic          verdict_load;

   rv32i_wb_shadow u_shadow (
      .sys_clk     (sys_clk_i),
      .rst         (rst_i),
      .clr         (start_i),
      .en          (shadow_en),
      .wb_en       (wb_en_i),
      .wb_rd       (wb_rd_i),
      .wb_data     (wb_data_i),
      .testnum_nxt (testnum_nxt),
      .done_nxt    (done_nxt),
      .result_nxt  (result_nxt)
   );

   always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // x26 shadow is always zero while in RUN, so a non-zero next value means a trigger write.
   always_comb begin
      state_nxt   = state;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      shadow_en   = 1'b0;
      trigger     = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: ;
         ST_RUN: begin
            busy_o    = 1'b1;
            shadow_en = 1'b1;
            if (done_nxt != 32'd0) begin
               trigger   = 1'b1;
               state_nxt = ST_SETTLE;
            end else if (cycle_cnt == TIMEOUT_LAST) begin
               timeout_hit = 1'b1;
               state_nxt   = ST_DONE;
            end
         end
         ST_SETTLE: begin
            busy_o    = 1'b1;
            shadow_en = 1'b1;
            if (settle_cnt == '0) state_nxt = ST_DONE;
         end
         ST_DONE: done_o = 1'b1;
         default: state_nxt = ST_IDLE;
      endcase
      if (start_i) state_nxt = ST_RUN;
      verdict_load = (state != ST_DONE) && (state_nxt == ST_DONE);
   end

   always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycle_cnt      <= '0;
         settle_cnt     <= '0;
         pass_o         <= 1'b0;
         fail_o         <= 1'b0;
         timeout_o      <= 1'b0;
         fail_testnum_o <= '0;
      end else if (start_i) begin
         // start cycle counts as cycle 0, so the first RUN cycle reads 1
         cycle_cnt      <= 32'd1;
         settle_cnt     <= '0;
         pass_o         <= 1'b0;
         fail_o         <= 1'b0;
         timeout_o      <= 1'b0;
         fail_testnum_o <= '0;
      end else begin
         if (busy_o && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 32'd1;
         if (trigger)                 settle_cnt <= SETTLE_LOAD;
         else if (settle_cnt != '0)   settle_cnt <= settle_cnt - SW'(1);
         if (verdict_load) begin
            if (timeout_hit) begin
               timeout_o      <= 1'b1;
               fail_testnum_o <= testnum_nxt;
            end else if (result_nxt == PASS_VALUE) begin
               pass_o         <= 1'b1;
               fail_testnum_o <= '0;
            end else begin
               fail_o         <= 1'b1;
               fail_testnum_o <= testnum_nxt;
            end
         end
      end
   end

   assign cycle_count_o = cycle_cnt;

endmodule
